// File: rtl/serial_add_sub_pkg.sv
// ============================================================================
// Module      : serial_add_sub_pkg
// Description : Shared FSM state and operation encodings for the bit-serial
//               adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_add_sub_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_st_idle = 2'd0;
    localparam state_t c_st_run  = 2'd1;
    localparam state_t c_st_done = 2'd2;

    localparam logic c_op_add = 1'b0;
    localparam logic c_op_sub = 1'b1;

endpackage : serial_add_sub_pkg

`default_nettype wire

// File: rtl/fullAdderNOR.sv
// ============================================================================
// Module      : fullAdderNOR
// Description : One-bit full adder built from two-input and three-input NORs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fullAdderNOR (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    logic w_ab_n;
    logic w_a_only;
    logic w_b_only;
    logic w_ab_xnor;
    logic w_ab_xor;
    logic w_pc_n;
    logic w_p_only;
    logic w_c_only;
    logic w_sum_xnor;
    logic w_ac_n;
    logic w_bc_n;

    // XOR is formed as NOR of the two "one-but-not-other" terms, then inverted.
    assign w_ab_n     = ~(i_a | i_b);
    assign w_a_only   = ~(i_a | w_ab_n);
    assign w_b_only   = ~(i_b | w_ab_n);
    assign w_ab_xnor  = ~(w_a_only | w_b_only);
    assign w_ab_xor   = ~(w_ab_xnor | w_ab_xnor);

    assign w_pc_n     = ~(w_ab_xor | i_cin);
    assign w_p_only   = ~(w_ab_xor | w_pc_n);
    assign w_c_only   = ~(i_cin | w_pc_n);
    assign w_sum_xnor = ~(w_p_only | w_c_only);
    assign o_sum      = ~(w_sum_xnor | w_sum_xnor);

    // Majority = (a|b)&(a|c)&(b|c) = NOR of the three pairwise NORs.
    assign w_ac_n     = ~(i_a | i_cin);
    assign w_bc_n     = ~(i_b | i_cin);
    assign o_cout     = ~(w_ab_n | w_ac_n | w_bc_n);

endmodule : fullAdderNOR

`default_nettype wire

// File: rtl/serial_add_sub.sv
// ============================================================================
// Module      : serial_add_sub
// Description : Bit-serial WIDTH-bit adder/subtractor, LSB first, one bit per
//               clock through a single full-adder slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_ovf;

    logic w_sum;
    logic w_slice_cout;

    fullAdderNOR u_slice (
        .i_a    (r_a_sr[0]),
        .i_b    (r_b_sr[0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_slice_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        // Subtract as a + ~b + 1: invert B at load, seed carry with 1.
                        r_a_sr  <= a;
                        r_b_sr  <= b ^ {WIDTH{sub}};
                        r_carry <= (sub == c_op_sub);
                        r_cnt   <= '0;
                        r_state <= c_st_run;
                    end
                end
                c_st_run: begin
                    r_result <= {w_sum, r_result[WIDTH-1:1]};
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_carry  <= w_slice_cout;
                    if (r_cnt == c_last_bit) begin
                        // r_carry is the carry into the MSB on this final bit.
                        r_cout  <= w_slice_cout;
                        r_ovf   <= r_carry ^ w_slice_cout;
                        r_state <= c_st_done;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign busy     = (r_state == c_st_run);
    assign done     = (r_state == c_st_done);
    assign result   = r_result;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule : serial_add_sub

`default_nettype wire

// File: tb/tb_serial_add_sub.sv
// ============================================================================
// Module      : tb_serial_add_sub
// Description : Self-checking bench for serial_add_sub against an arithmetic
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_add_sub;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    int n_cmp;
    int n_err;

    logic [WIDTH-1:0] last_r;
    logic             last_c;
    logic             last_v;

    serial_add_sub #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  input logic s, output logic [WIDTH-1:0] r,
                                  output logic c, output logic v);
        int ux, uy, sx, sy, full, sres;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            full = ux - uy;
            sres = sx - sy;
            c    = (ux >= uy);
        end else begin
            full = ux + uy;
            sres = sx + sy;
            c    = (full > 255);
        end
        r = full[WIDTH-1:0];
        v = (sres > 127) || (sres < -128);
    endfunction

    // Called at a negedge; returns at a negedge one cycle after done was seen.
    task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                         input logic ts, input int poke_run, input bit poke_done);
        logic [WIDTH-1:0] er;
        logic             ec;
        logic             ev;
        int               n;
        int               busy_n;
        model(ta, tb_v, ts, er, ec, ev);
        a = ta; b = tb_v; sub = ts; start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        n      = 0;
        busy_n = 0;
        while (!done && n <= 3 * WIDTH) begin
            if (busy) busy_n++;
            if (n == poke_run) begin
                start = 1'b1; a = ~ta; b = $urandom; sub = ~ts;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        chk("latency", n, WIDTH);
        chk("busy_cycles", busy_n, WIDTH);
        chk("busy_in_done", busy, 1'b0);
        chk("result", result, er);
        chk("cout", cout, ec);
        chk("overflow", overflow, ev);
        last_r = er; last_c = ec; last_v = ev;
        start = poke_done;
        if (poke_done) begin a = $urandom; b = $urandom; end
        @(negedge clk);
        start = 1'b0;
        chk("done_pulse", done, 1'b0);
        chk("idle_not_busy", busy, 1'b0);
        chk("result_held", result, er);
    endtask

    initial begin
        int seen;
        int n;
        n_cmp = 0; n_err = 0;
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;
        @(negedge clk);

        do_op(8'h3C, 8'h0F, 1'b0, -1, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, -1, 1'b0);
        do_op(8'h7F, 8'h01, 1'b0, -1, 1'b0);
        do_op(8'h05, 8'h07, 1'b1, -1, 1'b0);
        do_op(8'h80, 8'h01, 1'b1, -1, 1'b0);

        // Starts during RUN and DONE are dropped; the following IDLE start is taken.
        do_op(8'h12, 8'h34, 1'b0, 3, 1'b1);
        do_op(8'hA0, 8'h5B, 1'b1, -1, 1'b0);

        // Reset during RUN aborts without a done pulse.
        a = 8'h55; b = 8'h66; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_result", result, 0);
        chk("abort_cout", cout, 0);
        chk("abort_ovf", overflow, 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) seen++;
            @(negedge clk);
        end
        chk("abort_no_done", seen, 0);
        do_op(8'h01, 8'h01, 1'b0, -1, 1'b0);

        // rst wins over a simultaneous start.
        rst = 1'b1; start = 1'b1; a = 8'h11; b = 8'h22;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            if (busy || done) n++;
            @(negedge clk);
        end
        chk("rst_start_idle", n, 0);

        for (int i = 0; i < 30; i++) begin
            do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), -1, 1'b0);
        end

        for (int i = 0; i < 20; i++) begin
            a = $urandom; b = $urandom; sub = 1'($urandom);
            @(negedge clk);
            chk("hold_result", result, last_r);
            chk("hold_cout", cout, last_c);
            chk("hold_ovf", overflow, last_v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_serial_add_sub

`default_nettype wire
